// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between a fetch port and a data port.
// The data port has priority; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module mem_port_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk_i,
    input  logic          clr_i,
    input  logic          i_req_i,
    input  logic [AW-1:0] i_addr_i,
    output logic          i_ack_o,
    output logic          i_rvalid_o,
    output logic [DW-1:0] i_rdata_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic          d_ack_o,
    output logic          d_rvalid_o,
    output logic [DW-1:0] d_rdata_o,
    output logic          m_en_o,
    output logic          m_we_o,
    output logic [AW-1:0] m_addr_o,
    output logic [DW-1:0] m_wdata_o,
    input  logic [DW-1:0] m_rdata_i,
    output logic          busy_o
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam int unsigned LW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic            owner_q, owner_d;  // 1 = fetch port owns the access
    logic            i_ack_q, i_ack_d, d_ack_q, d_ack_d;
    logic            i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic [DW-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic            m_en_q, m_en_d, m_we_q, m_we_d;
    logic [AW-1:0]   m_addr_q, m_addr_d;
    logic [DW-1:0]   m_wdata_q, m_wdata_d;
    logic            busy_q, busy_d;
    logic            grant_i;

    assign grant_i = i_req_i && (!d_req_i || (starve_q == SW'(STARVE_MAX)));

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        lat_d      = lat_q;
        owner_d    = owner_q;
        i_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        m_en_d     = 1'b0;
        m_we_d     = 1'b0;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;

        if (!i_req_i) begin
            starve_d = '0;
        end

        unique case (state_q)
            StIdle: begin
                if (i_req_i || d_req_i) begin
                    state_d = StIssue;
                    m_en_d  = 1'b1;
                    owner_d = grant_i;
                    if (grant_i) begin
                        i_ack_d  = 1'b1;
                        m_addr_d = i_addr_i;
                        starve_d = '0;
                    end else begin
                        d_ack_d   = 1'b1;
                        m_we_d    = d_we_i;
                        m_addr_d  = d_addr_i;
                        m_wdata_d = d_wdata_i;
                        if (i_req_i && (starve_q != SW'(STARVE_MAX))) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end
                end
            end
            StIssue: begin
                if (m_we_q) begin
                    state_d = StIdle;
                end else begin
                    state_d = StWait;
                    lat_d   = LW'(MEM_LAT);
                end
            end
            StWait: begin
                lat_d = lat_q - LW'(1);
                // Last wait cycle: memory data is valid now, capture for the owner.
                if (lat_q == LW'(1)) begin
                    state_d = StResp;
                    if (owner_q) begin
                        i_rdata_d  = m_rdata_i;
                        i_rvalid_d = 1'b1;
                    end else begin
                        d_rdata_d  = m_rdata_i;
                        d_rvalid_d = 1'b1;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q    <= StIdle;
            starve_q   <= '0;
            lat_q      <= '0;
            owner_q    <= 1'b0;
            i_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            m_en_q     <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            lat_q      <= lat_d;
            owner_q    <= owner_d;
            i_ack_q    <= i_ack_d;
            d_ack_q    <= d_ack_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            m_en_q     <= m_en_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign i_ack_o    = i_ack_q;
    assign d_ack_o    = d_ack_q;
    assign i_rvalid_o = i_rvalid_q;
    assign d_rvalid_o = d_rvalid_q;
    assign i_rdata_o  = i_rdata_q;
    assign d_rdata_o  = d_rdata_q;
    assign m_en_o     = m_en_q;
    assign m_we_o     = m_we_q;
    assign m_addr_o   = m_addr_q;
    assign m_wdata_o  = m_wdata_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance a has MEM_LAT=1, instance b has MEM_LAT=3.
// Each instance drives its own latency-accurate memory model.
module tb_mem_port_arbiter;

    logic clk;
    logic clr;

    logic        a_i_req, a_i_ack, a_i_rvalid;
    logic [31:0] a_i_addr, a_i_rdata;
    logic        a_d_req, a_d_we, a_d_ack, a_d_rvalid;
    logic [31:0] a_d_addr, a_d_wdata, a_d_rdata;
    logic        a_m_en, a_m_we, a_busy;
    logic [31:0] a_m_addr, a_m_wdata, a_m_rdata;

    logic        b_i_req, b_i_ack, b_i_rvalid;
    logic [31:0] b_i_addr, b_i_rdata;
    logic        b_d_req, b_d_we, b_d_ack, b_d_rvalid;
    logic [31:0] b_d_addr, b_d_wdata, b_d_rdata;
    logic        b_m_en, b_m_we, b_busy;
    logic [31:0] b_m_addr, b_m_wdata, b_m_rdata;

    logic [31:0] pipe_a, pipe_b0, pipe_b1, pipe_b2;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut_a (
        .clk_i(clk), .clr_i(clr),
        .i_req_i(a_i_req), .i_addr_i(a_i_addr), .i_ack_o(a_i_ack),
        .i_rvalid_o(a_i_rvalid), .i_rdata_o(a_i_rdata),
        .d_req_i(a_d_req), .d_we_i(a_d_we), .d_addr_i(a_d_addr), .d_wdata_i(a_d_wdata),
        .d_ack_o(a_d_ack), .d_rvalid_o(a_d_rvalid), .d_rdata_o(a_d_rdata),
        .m_en_o(a_m_en), .m_we_o(a_m_we), .m_addr_o(a_m_addr), .m_wdata_o(a_m_wdata),
        .m_rdata_i(a_m_rdata), .busy_o(a_busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut_b (
        .clk_i(clk), .clr_i(clr),
        .i_req_i(b_i_req), .i_addr_i(b_i_addr), .i_ack_o(b_i_ack),
        .i_rvalid_o(b_i_rvalid), .i_rdata_o(b_i_rdata),
        .d_req_i(b_d_req), .d_we_i(b_d_we), .d_addr_i(b_d_addr), .d_wdata_i(b_d_wdata),
        .d_ack_o(b_d_ack), .d_rvalid_o(b_d_rvalid), .d_rdata_o(b_d_rdata),
        .m_en_o(b_m_en), .m_we_o(b_m_we), .m_addr_o(b_m_addr), .m_wdata_o(b_m_wdata),
        .m_rdata_i(b_m_rdata), .busy_o(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h40) return 32'h8C010004;
        return 32'hC0DE0000 ^ a;
    endfunction

    // Poison value marks cycles where the memory output is not valid.
    always @(posedge clk) begin
        pipe_a  <= a_m_en ? mem_word(a_m_addr) : 32'hBAD0BAD0;
        pipe_b0 <= b_m_en ? mem_word(b_m_addr) : 32'hBAD0BAD0;
        pipe_b1 <= pipe_b0;
        pipe_b2 <= pipe_b1;
    end
    assign a_m_rdata = pipe_a;
    assign b_m_rdata = pipe_b2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ia, da, exp_i, exp_d;
        logic        is_i;

        a_i_req = 1'b1; a_i_addr = 32'h80;
        a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 32'h20; a_d_wdata = 32'h11112222;
        b_i_req = 1'b0; b_i_addr = 32'h0;
        b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = 32'h0; b_d_wdata = 32'h0;
        clr = 1'b1;

        // 1: reset with both requests pending
        tick();
        tick();
        check("t1_flags", {25'b0, a_i_ack, a_d_ack, a_i_rvalid, a_d_rvalid, a_m_en, a_m_we, a_busy},
              32'h0);
        check("t1_m_addr", a_m_addr, 32'h0);
        check("t1_m_wdata", a_m_wdata, 32'h0);
        check("t1_i_rdata", a_i_rdata, 32'h0);
        check("t1_d_rdata", a_d_rdata, 32'h0);
        check("t1_b_busy", b_busy, 1'b0);
        clr = 1'b0;
        tick();
        check("t1_d_ack", a_d_ack, 1'b1);
        check("t1_i_ack", a_i_ack, 1'b0);
        check("t1_busy", a_busy, 1'b1);
        check("t1_m_addr_wr", a_m_addr, 32'h20);
        a_i_req = 1'b0;
        a_d_req = 1'b0;
        tick();
        check("t1_idle", a_busy, 1'b0);

        // 2: single fetch read, MEM_LAT=1
        a_i_req = 1'b1; a_i_addr = 32'h40;
        tick();
        check("t2_i_ack", a_i_ack, 1'b1);
        check("t2_m_en", a_m_en, 1'b1);
        check("t2_m_we", a_m_we, 1'b0);
        check("t2_m_addr", a_m_addr, 32'h40);
        check("t2_d_ack", a_d_ack, 1'b0);
        a_i_req = 1'b0;
        tick();
        check("t2_rvalid_early", a_i_rvalid, 1'b0);
        check("t2_m_en_off", a_m_en, 1'b0);
        tick();
        check("t2_i_rvalid", a_i_rvalid, 1'b1);
        check("t2_i_rdata", a_i_rdata, 32'h8C010004);
        check("t2_d_rvalid", a_d_rvalid, 1'b0);
        tick();
        check("t2_rvalid_pulse", a_i_rvalid, 1'b0);
        check("t2_rdata_hold", a_i_rdata, 32'h8C010004);
        check("t2_busy_end", a_busy, 1'b0);

        // 3: data write
        a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 32'h10; a_d_wdata = 32'hDEADBEEF;
        tick();
        check("t3_d_ack", a_d_ack, 1'b1);
        check("t3_m_en_we", {30'b0, a_m_en, a_m_we}, 32'h3);
        check("t3_m_addr", a_m_addr, 32'h10);
        check("t3_m_wdata", a_m_wdata, 32'hDEADBEEF);
        a_d_req = 1'b0;
        tick();
        check("t3_m_en_we_off", {30'b0, a_m_en, a_m_we}, 32'h0);
        check("t3_d_rvalid", a_d_rvalid, 1'b0);
        check("t3_busy", a_busy, 1'b0);
        check("t3_addr_hold", a_m_addr, 32'h10);
        check("t3_wdata_hold", a_m_wdata, 32'hDEADBEEF);

        // 5: clr during WAIT of a data read; d_rdata has held 0 since reset
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h30;
        tick();
        check("t5_d_ack", a_d_ack, 1'b1);
        a_d_req = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t5_busy", a_busy, 1'b0);
        check("t5_d_rvalid", a_d_rvalid, 1'b0);
        check("t5_d_rdata", a_d_rdata, 32'h0);
        tick();
        check("t5_d_rvalid_after", a_d_rvalid, 1'b0);
        check("t5_d_rdata_after", a_d_rdata, 32'h0);
        check("t5_idle", a_busy, 1'b0);

        // 4: both ports held requesting reads; starvation forces every 5th grant to fetch
        ia = 32'h200; da = 32'h100; exp_i = 32'h0; exp_d = 32'h0;
        a_i_addr = ia; a_d_addr = da; a_d_we = 1'b0;
        a_i_req = 1'b1; a_d_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            is_i = ((k % 5) == 4);
            tick();
            check($sformatf("t4_i_ack_%0d", k), a_i_ack, is_i);
            check($sformatf("t4_d_ack_%0d", k), a_d_ack, !is_i);
            check($sformatf("t4_m_addr_%0d", k), a_m_addr, is_i ? ia : da);
            if (is_i) begin
                exp_i = mem_word(ia);
                ia = ia + 32'h4;
                a_i_addr = ia;
            end else begin
                exp_d = mem_word(da);
                da = da + 32'h4;
                a_d_addr = da;
            end
            tick();
            tick();
            check($sformatf("t4_i_rvalid_%0d", k), a_i_rvalid, is_i);
            check($sformatf("t4_d_rvalid_%0d", k), a_d_rvalid, !is_i);
            check($sformatf("t4_i_rdata_%0d", k), a_i_rdata, exp_i);
            check($sformatf("t4_d_rdata_%0d", k), a_d_rdata, exp_d);
            if (k == 9) begin
                a_i_req = 1'b0;
                a_d_req = 1'b0;
            end
            tick();
        end
        tick();
        check("t4_idle", a_busy, 1'b0);

        // 6: MEM_LAT=3, back-to-back fetch reads at 0x0 and 0x4
        b_i_req = 1'b1; b_i_addr = 32'h0;
        tick();
        check("t6_ack0", b_i_ack, 1'b1);
        check("t6_m_en0", b_m_en, 1'b1);
        check("t6_m_addr0", b_m_addr, 32'h0);
        b_i_addr = 32'h4;
        tick();
        tick();
        tick();
        check("t6_rvalid0_early", b_i_rvalid, 1'b0);
        tick();
        check("t6_rvalid0", b_i_rvalid, 1'b1);
        check("t6_rdata0", b_i_rdata, mem_word(32'h0));
        tick();
        check("t6_m_en_gap", b_m_en, 1'b0);
        tick();
        check("t6_ack1", b_i_ack, 1'b1);
        check("t6_m_en1", b_m_en, 1'b1);
        check("t6_m_addr1", b_m_addr, 32'h4);
        b_i_req = 1'b0;
        tick();
        tick();
        tick();
        check("t6_rvalid1_early", b_i_rvalid, 1'b0);
        tick();
        check("t6_rvalid1", b_i_rvalid, 1'b1);
        check("t6_rdata1", b_i_rdata, mem_word(32'h4));
        check("t6_d_rvalid", b_d_rvalid, 1'b0);
        tick();
        check("t6_busy_end", b_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
